// File: rtl/alkmdseq_pkg.sv
// Shared definitions for the ALK multiply/divide step sequencer:
// ALPCTL override codes, sequencer state encoding and the opcode select.
package alkpkg;

  localparam logic [9:0] ALP_MULFASTP = 10'h279;
  localparam logic [9:0] ALP_MULFASTN = 10'h269;
  localparam logic [9:0] ALP_DIVFASTP = 10'h26C;
  localparam logic [9:0] ALP_DIVFASTN = 10'h27C;
  localparam logic [9:0] ALP_DIVDA    = 10'h27F;
  localparam logic [9:0] ALP_DIVDS    = 10'h26F;
  localparam logic [9:0] ALP_REM      = 10'h26A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOOP  = 3'd2,
    ST_FIX   = 3'd3,
    ST_REM   = 3'd4
  } state_t;

  // Opcode issued through SETUP and every LOOP cycle; ALK alternates ADD/SUB itself.
  function automatic logic [9:0] seq_opcode(input logic div, input logic neg);
    logic [9:0] code;
    if (div) code = neg ? ALP_DIVFASTN : ALP_DIVFASTP;
    else     code = neg ? ALP_MULFASTN : ALP_MULFASTP;
    return code;
  endfunction

endpackage

// File: rtl/alkmdseq_if.sv
// Microword/ALK-side signal bundle of the multiply/divide sequencer.
// start_h is a request sampled only while idle (and not stalled); there is no
// ready/ack: busy_h high means any start_h is ignored, done_h marks the last override.
interface alkmdseq_if #(
  parameter int N_ITER = 32,
  parameter int CW     = $clog2(N_ITER + 1)
);
  import alkpkg::*;

  logic [9:0]    ualpctl_h;
  logic          start_h;
  logic          div_h;
  logic          neg_h;
  logic          rem_req_h;
  logic          rem_neg_h;
  logic          stall_h;
  logic [9:0]    alpctl_h;
  logic          busy_h;
  logic          done_h;
  logic [CW-1:0] iter_h;
  state_t        state;

  modport master (
    output ualpctl_h, start_h, div_h, neg_h, rem_req_h, rem_neg_h, stall_h,
    input  alpctl_h, busy_h, done_h, iter_h, state
  );

  modport slave (
    input  ualpctl_h, start_h, div_h, neg_h, rem_req_h, rem_neg_h, stall_h,
    output alpctl_h, busy_h, done_h, iter_h, state
  );

endinterface

// File: rtl/alkmdseq_iter.sv
// LOOP step counter: clears to 0, counts while enabled and parks at N_ITER-1.
module alkmditer #(
  parameter int N_ITER = 32,
  parameter int CW     = $clog2(N_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TERM = CW'(N_ITER - 1);

  assign tc = (cnt == TERM);

  // Never wraps: terminal count forces the sequencer out of LOOP instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !tc)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alkmdseq.sv
// Multiply/divide step sequencer: overrides the microword ALPCTL with
// SETUP, N_ITER LOOP steps and the divide fix-up/remainder steps.
module alkmdseq
  import alkpkg::*;
#(
  parameter int N_ITER = 32
) (
  input logic       qdclk_l,
  input logic       reset_l,
  alkmdseq_if.slave bus
);

  localparam int CW = $clog2(N_ITER + 1);

  state_t        state, state_nxt;
  logic          div_q, div_nxt;
  logic          neg_q, neg_nxt;
  logic          rem_q, rem_nxt;
  logic          fixneg_q, fixneg_nxt;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt;
  logic [9:0]    alpctl;
  logic          busy, done;

  alkmditer #(.N_ITER(N_ITER), .CW(CW)) u_iter (
    .clk   (qdclk_l),
    .rst_n (reset_l),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rem_q    <= 1'b0;
      fixneg_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_q    <= div_nxt;
      neg_q    <= neg_nxt;
      rem_q    <= rem_nxt;
      fixneg_q <= fixneg_nxt;
    end
  end

  // Every transition is gated by stall_h so a stalled cycle repeats exactly.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_q;
    neg_nxt    = neg_q;
    rem_nxt    = rem_q;
    fixneg_nxt = fixneg_q;
    alpctl     = bus.ualpctl_h;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start_h && !bus.stall_h) begin
          div_nxt   = bus.div_h;
          neg_nxt   = bus.neg_h;
          rem_nxt   = bus.rem_req_h;
          state_nxt = ST_SETUP;
        end
      end

      ST_SETUP: begin
        busy   = 1'b1;
        alpctl = seq_opcode(div_q, neg_q);
        if (!bus.stall_h) state_nxt = ST_LOOP;
      end

      ST_LOOP: begin
        busy    = 1'b1;
        alpctl  = seq_opcode(div_q, neg_q);
        cnt_clr = 1'b0;
        cnt_en  = !bus.stall_h;
        if (!bus.stall_h && cnt_tc) begin
          if (div_q) begin
            fixneg_nxt = bus.rem_neg_h;
            state_nxt  = ST_FIX;
          end else begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_FIX: begin
        busy   = 1'b1;
        alpctl = fixneg_q ? ALP_DIVDA : ALP_DIVDS;
        if (!bus.stall_h) begin
          done      = !rem_q;
          state_nxt = rem_q ? ST_REM : ST_IDLE;
        end
      end

      ST_REM: begin
        busy   = 1'b1;
        alpctl = ALP_REM;
        if (!bus.stall_h) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.alpctl_h = alpctl;
  assign bus.busy_h   = busy;
  assign bus.done_h   = done;
  assign bus.iter_h   = (state == ST_LOOP) ? cnt : '0;
  assign bus.state    = state;

endmodule

// File: tb/tb_alkmdseq.sv
// Bench for alkmdseq: directed scenarios plus random traffic, checked each
// cycle against a step-queue model of the override sequence.
module tb_alkmdseq;

  localparam int N_ITER = 32;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int W      = 12 + CW;   // {is_fix, last_loop, iter, code}

  logic qdclk_l = 1'b0;
  logic reset_l = 1'b0;

  alkmdseq_if #(.N_ITER(N_ITER)) bus ();

  alkmdseq #(.N_ITER(N_ITER)) dut (
    .qdclk_l (qdclk_l),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  always #5 qdclk_l = ~qdclk_l;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of overridden cycles still to be shown, one entry per unstalled cycle.
  logic [W-1:0] exp_q[$];
  logic         fixneg_m = 1'b0;
  logic         div_m    = 1'b0;
  logic [W-1:0] h;
  logic [9:0]   e_alp;
  logic         e_busy, e_done;
  logic [CW-1:0] e_iter;
  logic [9:0]   code_m;

  int         run_len   = 0;
  int         last_len  = 0;
  int         done_cnt  = 0;
  logic [9:0] done_code = '0;
  logic [9:0] done_prev = '0;
  logic [9:0] prev_alp  = '0;

  always @(negedge qdclk_l) begin
    if (!reset_l) begin
      exp_q.delete();
      fixneg_m = 1'b0;
    end
    h = '0;
    if (exp_q.size() == 0) begin
      e_alp  = bus.ualpctl_h;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_iter = '0;
    end else begin
      h      = exp_q[0];
      e_alp  = h[W-1] ? (fixneg_m ? 10'h27F : 10'h26F) : h[9:0];
      e_busy = 1'b1;
      e_done = (exp_q.size() == 1) && !bus.stall_h;
      e_iter = h[10 +: CW];
    end
    chk("cmp_alpctl", bus.alpctl_h, e_alp);
    chk("cmp_busy",   bus.busy_h,   e_busy);
    chk("cmp_done",   bus.done_h,   e_done);
    chk("cmp_iter",   bus.iter_h,   e_iter);

    if (bus.busy_h) run_len++;
    else if (run_len != 0) begin
      last_len = run_len;
      run_len  = 0;
    end
    if (bus.done_h) begin
      done_cnt++;
      done_code = bus.alpctl_h;
      done_prev = prev_alp;
    end
    prev_alp = bus.alpctl_h;

    if (reset_l) begin
      if (exp_q.size() == 0) begin
        if (bus.start_h && !bus.stall_h) begin
          div_m  = bus.div_h;
          if (bus.div_h) code_m = bus.neg_h ? 10'h27C : 10'h26C;
          else           code_m = bus.neg_h ? 10'h269 : 10'h279;
          exp_q.push_back({1'b0, 1'b0, CW'(0), code_m});
          for (int i = 0; i < N_ITER; i++)
            exp_q.push_back({1'b0, (i == N_ITER - 1), CW'(i), code_m});
          if (bus.div_h) begin
            exp_q.push_back({1'b1, 1'b0, CW'(0), 10'h000});
            if (bus.rem_req_h) exp_q.push_back({1'b0, 1'b0, CW'(0), 10'h26A});
          end
        end
      end else if (!bus.stall_h) begin
        if (h[W-2] && div_m) fixneg_m = bus.rem_neg_h;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge qdclk_l);
    #1;
    bus.ualpctl_h = 10'($urandom);
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (!bus.busy_h) ok = 1;
      else next_cycle();
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
    @(negedge qdclk_l);
    #1;
  endtask

  task automatic wait_iter(input string name, input int target);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.busy_h && bus.iter_h == CW'(target)) ok = 1;
      else next_cycle();
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic launch(input logic div, input logic neg, input logic rem);
    next_cycle();
    bus.start_h   = 1'b1;
    bus.div_h     = div;
    bus.neg_h     = neg;
    bus.rem_req_h = rem;
    next_cycle();
    bus.start_h   = 1'b0;
  endtask

  int d0;

  initial begin
    bus.ualpctl_h = 10'h155;
    bus.start_h   = 1'b0;
    bus.div_h     = 1'b0;
    bus.neg_h     = 1'b0;
    bus.rem_req_h = 1'b0;
    bus.rem_neg_h = 1'b0;
    bus.stall_h   = 1'b0;
    repeat (2) @(posedge qdclk_l);
    @(negedge qdclk_l);
    #1;
    chk("rst_busy",   bus.busy_h,   0);
    chk("rst_done",   bus.done_h,   0);
    chk("rst_iter",   bus.iter_h,   0);
    chk("rst_alpctl", bus.alpctl_h, bus.ualpctl_h);
    next_cycle();
    reset_l = 1'b1;

    // MUL, positive
    d0 = done_cnt;
    launch(1'b0, 1'b0, 1'b0);
    wait_idle("mul", 200);
    chk("mul_len",    last_len, 33);
    chk("mul_dcode",  done_code, 10'h279);
    chk("mul_ndone",  done_cnt - d0, 1);
    chk("mul_pass",   bus.alpctl_h, bus.ualpctl_h);

    // DIV, negative, fix-up add, remainder step
    d0 = done_cnt;
    bus.rem_neg_h = 1'b1;
    launch(1'b1, 1'b1, 1'b1);
    wait_idle("divrem", 200);
    chk("divrem_len",   last_len, 35);
    chk("divrem_dcode", done_code, 10'h26A);
    chk("divrem_fix",   done_prev, 10'h27F);
    chk("divrem_ndone", done_cnt - d0, 1);

    // DIV, positive, fix-up subtract, no remainder
    d0 = done_cnt;
    bus.rem_neg_h = 1'b0;
    launch(1'b1, 1'b0, 1'b0);
    wait_idle("div", 200);
    chk("div_len",   last_len, 34);
    chk("div_dcode", done_code, 10'h26F);
    chk("div_prev",  done_prev, 10'h26C);
    chk("div_pass",  bus.alpctl_h, bus.ualpctl_h);

    // Stall 3 cycles at iter 5
    d0 = done_cnt;
    launch(1'b0, 1'b1, 1'b0);
    wait_iter("stall", 5);
    bus.stall_h = 1'b1;
    next_cycle();
    chk("stall_iter", bus.iter_h, 5);
    chk("stall_alp",  bus.alpctl_h, 10'h269);
    next_cycle();
    next_cycle();
    bus.stall_h = 1'b0;
    wait_idle("stall", 200);
    chk("stall_len",   last_len, 36);
    chk("stall_ndone", done_cnt - d0, 1);
    chk("stall_dcode", done_code, 10'h269);

    // Reset mid-sequence at iter 10
    launch(1'b0, 1'b0, 1'b0);
    wait_iter("rstmid", 10);
    reset_l = 1'b0;
    #1;
    chk("rstmid_busy", bus.busy_h, 0);
    chk("rstmid_iter", bus.iter_h, 0);
    chk("rstmid_alp",  bus.alpctl_h, bus.ualpctl_h);
    next_cycle();
    reset_l = 1'b1;

    // Full sequence after reset, with a start pulse mid-sequence
    d0 = done_cnt;
    launch(1'b0, 1'b0, 1'b0);
    repeat (7) next_cycle();
    bus.start_h = 1'b1;
    next_cycle();
    bus.start_h = 1'b0;
    wait_idle("midstart", 200);
    chk("midstart_len",   last_len, 33);
    chk("midstart_ndone", done_cnt - d0, 1);
    repeat (3) next_cycle();
    chk("midstart_idle", bus.busy_h, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      bus.start_h   = ($urandom_range(0, 3) == 0);
      bus.div_h     = 1'($urandom);
      bus.neg_h     = 1'($urandom);
      bus.rem_req_h = 1'($urandom);
      bus.rem_neg_h = 1'($urandom);
      bus.stall_h   = ($urandom_range(0, 7) == 0);
      reset_l       = ($urandom_range(0, 299) != 0);
    end
    next_cycle();
    reset_l     = 1'b1;
    bus.start_h = 1'b0;
    bus.stall_h = 1'b0;
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
